// File: rtl/ahbl_excl_monitor_pkg.sv
// -----------------------------------------------------------------------------
// ahbl_excl_monitor_pkg
//   Shared bus-fabric configuration for the AHB-Lite exclusive-access monitor:
//   HTRANS encodings, the default reservation granule, and the address-phase
//   acceptance helper used by every block that tracks AHB-Lite transfers.
// -----------------------------------------------------------------------------
package ahbl_excl_monitor_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Default reservation granule: 8 bytes.
    localparam int GRANULE_LOG2_DEFAULT = 3;

    // An address phase is taken by the bus when HREADY is high and the
    // transfer is NONSEQ or SEQ (HTRANS[1] set).
    function automatic logic addr_phase_accepted(input logic       hready,
                                                 input logic [1:0] htrans);
        return hready && htrans[1];
    endfunction

endpackage

// File: rtl/excl_resv_slot.sv
// -----------------------------------------------------------------------------
// excl_resv_slot
//   One exclusive-access reservation: a valid bit plus the granule tag of the
//   reserved address.
//
// Ports
//   clk        in   clock, state updates on rising edge
//   rst_n      in   synchronous active-low reset (clears valid only)
//   set_i      in   load tag_i and mark the reservation valid
//   clr_i      in   drop the reservation
//   tag_i      in   granule tag of the current address phase
//   match_o    out  reservation is valid and its tag equals tag_i
// -----------------------------------------------------------------------------
module excl_resv_slot #(
    parameter int TAG_W = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             match_o
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Set and clear never coincide (read vs. write), but set wins if they did.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (set_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    // The tag is meaningless while invalid, so only the valid bit is reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q <= tag_d;
    end

    assign match_o = valid_q && (tag_q == tag_i);

endmodule

// File: rtl/ahbl_excl_monitor.sv
// -----------------------------------------------------------------------------
// ahbl_excl_monitor
//   AHB-Lite exclusive-access monitor sitting between the arbiter output and
//   the memory slave. It keeps one reservation per master, passes requests
//   through combinationally, suppresses failing exclusive writes (converted to
//   IDLE towards the slave and answered locally in one zero-wait cycle) and
//   generates HEXOKAY for successful exclusive transfers.
//
// Ports
//   clk, rst_n                     clock / synchronous active-low reset
//   src_h*  (in)                   upstream request incl. src_hexcl, src_hmaster
//   src_hready_resp, src_hresp,
//   src_hrdata, src_hexokay (out)  upstream response
//   dst_h*  (out)                  downstream request to the slave
//   dst_hready_resp, dst_hresp,
//   dst_hrdata (in)                slave response
// -----------------------------------------------------------------------------
module ahbl_excl_monitor
    import ahbl_excl_monitor_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int GRANULE_LOG2 = GRANULE_LOG2_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              src_hready,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,

    output logic              src_hready_resp,
    output logic              src_hresp,
    output logic [W_DATA-1:0] src_hrdata,
    output logic              src_hexokay,

    output logic              dst_hready,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,

    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int TAG_W = W_ADDR - GRANULE_LOG2;

    logic [TAG_W-1:0]     req_tag;
    logic                 accepted;
    logic                 is_excl_rd;
    logic [N_MASTERS-1:0] own_sel;
    logic [N_MASTERS-1:0] slot_match;
    logic [N_MASTERS-1:0] slot_set;
    logic [N_MASTERS-1:0] slot_clr;
    logic                 master_known;
    logic                 excl_pass;
    logic                 excl_fail;

    logic dp_excl_q, dp_excl_d;
    logic dp_fail_q, dp_fail_d;

    // ---- address phase: reservation lookup and update -----------------------
    assign req_tag    = src_haddr[W_ADDR-1:GRANULE_LOG2];
    assign accepted   = addr_phase_accepted(src_hready, src_htrans);
    assign is_excl_rd = src_hexcl && !src_hwrite;

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_slot
        assign own_sel[g]  = (src_hmaster == 8'(g));
        assign slot_set[g] = accepted && is_excl_rd && own_sel[g];
        // Any write that actually reaches memory kills every reservation on
        // that granule, the writer's own included.
        assign slot_clr[g] = accepted && src_hwrite && slot_match[g] &&
                             (!src_hexcl || excl_pass);

        excl_resv_slot #(
            .TAG_W (TAG_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .set_i   (slot_set[g]),
            .clr_i   (slot_clr[g]),
            .tag_i   (req_tag),
            .match_o (slot_match[g])
        );
    end

    // Unknown master IDs select no slot, so they never reserve and never pass.
    assign master_known = |own_sel;
    assign excl_pass    = |(own_sel & slot_match);
    // Evaluated whenever the transfer is presented, not just when accepted, so
    // the slave never sees a failing exclusive write even across wait states.
    assign excl_fail    = src_htrans[1] && src_hexcl && src_hwrite && !excl_pass;

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = excl_fail ? 2'(HTRANS_IDLE) : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;

    // ---- data phase: registered flags and response muxing -------------------
    always_comb begin
        dp_excl_d = dp_excl_q;
        dp_fail_d = dp_fail_q;
        if (src_hready) begin
            if (accepted) begin
                // An unreservable exclusive read completes as a plain read.
                dp_excl_d = src_hexcl && master_known;
                dp_fail_d = excl_fail;
            end else begin
                dp_excl_d = 1'b0;
                dp_fail_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_excl_q <= 1'b0;
            dp_fail_q <= 1'b0;
        end else begin
            dp_excl_q <= dp_excl_d;
            dp_fail_q <= dp_fail_d;
        end
    end

    // A failed write was never issued downstream, so its response is local:
    // OKAY, no wait states, no HEXOKAY.
    always_comb begin
        src_hready_resp = dst_hready_resp;
        src_hresp       = dst_hresp;
        src_hrdata      = dst_hrdata;
        src_hexokay     = dp_excl_q && dst_hready_resp && !dst_hresp;
        if (dp_fail_q) begin
            src_hready_resp = 1'b1;
            src_hresp       = 1'b0;
            src_hexokay     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
module tb_ahbl_excl_monitor;

    localparam int NM = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        src_hready;
    logic [31:0] src_haddr;
    logic        src_hwrite;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize;
    logic [2:0]  src_hburst;
    logic [3:0]  src_hprot;
    logic        src_hmastlock;
    logic [31:0] src_hwdata;
    logic        src_hexcl;
    logic [7:0]  src_hmaster;
    logic        src_hready_resp;
    logic        src_hresp;
    logic [31:0] src_hrdata;
    logic        src_hexokay;
    logic        dst_hready;
    logic [31:0] dst_haddr;
    logic        dst_hwrite;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize;
    logic [2:0]  dst_hburst;
    logic [3:0]  dst_hprot;
    logic        dst_hmastlock;
    logic [31:0] dst_hwdata;
    logic        dst_hready_resp;
    logic        dst_hresp;
    logic [31:0] dst_hrdata;

    int checks = 0;
    int errors = 0;

    ahbl_excl_monitor #(
        .N_MASTERS    (NM),
        .W_ADDR       (32),
        .W_DATA       (32),
        .GRANULE_LOG2 (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_hready      (src_hready),
        .src_haddr       (src_haddr),
        .src_hwrite      (src_hwrite),
        .src_htrans      (src_htrans),
        .src_hsize       (src_hsize),
        .src_hburst      (src_hburst),
        .src_hprot       (src_hprot),
        .src_hmastlock   (src_hmastlock),
        .src_hwdata      (src_hwdata),
        .src_hexcl       (src_hexcl),
        .src_hmaster     (src_hmaster),
        .src_hready_resp (src_hready_resp),
        .src_hresp       (src_hresp),
        .src_hrdata      (src_hrdata),
        .src_hexokay     (src_hexokay),
        .dst_hready      (dst_hready),
        .dst_haddr       (dst_haddr),
        .dst_hwrite      (dst_hwrite),
        .dst_htrans      (dst_htrans),
        .dst_hsize       (dst_hsize),
        .dst_hburst      (dst_hburst),
        .dst_hprot       (dst_hprot),
        .dst_hmastlock   (dst_hmastlock),
        .dst_hwdata      (dst_hwdata),
        .dst_hready_resp (dst_hready_resp),
        .dst_hresp       (dst_hresp),
        .dst_hrdata      (dst_hrdata)
    );

    // The bus HREADY seen by the monitor is the response it hands upstream.
    assign src_hready = src_hready_resp;

    // Memory slave with programmable wait states and optional ERROR response.
    int          ws_cfg  = 0;
    bit          err_cfg = 1'b0;
    logic        s_act;
    logic        s_wr;
    logic        s_err;
    logic [13:0] s_addr;
    int          s_cnt;
    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (!rst_n) begin
            s_act <= 1'b0;
            s_cnt <= 0;
        end else if (dst_hready) begin
            if (s_act && s_wr && !s_err) mem[s_addr[13:2]] <= dst_hwdata;
            s_act  <= dst_htrans[1];
            s_wr   <= dst_hwrite;
            s_addr <= dst_haddr[13:0];
            s_cnt  <= ws_cfg;
            s_err  <= err_cfg;
        end else if (s_act && s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
        end
    end

    assign dst_hready_resp = !s_act || (s_cnt == 0);
    assign dst_hresp       = s_act && s_err && (s_cnt == 0);
    assign dst_hrdata      = mem[s_addr[13:2]];

    // Reference model: one reservation (valid + granule number) per master,
    // plus the data the memory should hold for each written word.
    bit          mv [NM];
    logic [28:0] mt [NM];
    logic [31:0] shadow [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_hexokay", 32'(src_hexokay), 32'd0);
        check("rst_hready_resp", 32'(src_hready_resp), 32'(dst_hready_resp));
        check("rst_hresp", 32'(src_hresp), 32'(dst_hresp));
        rst_n = 1'b1;
        for (int i = 0; i < NM; i++) mv[i] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic [31:0] a, input bit wr, input bit ex,
                        input logic [31:0] wd, input int ws, input bit er);
        bit          known, pass, exp_fail, exp_ok, exp_resp, rdy;
        int          exp_cyc, cyc, idx;
        logic [28:0] tg;
        tg    = a[31:3];
        idx   = int'(a[13:2]);
        known = (m < NM);
        pass  = 1'b0;
        if (known) pass = mv[m] && (mt[m] == tg);
        exp_fail = wr && ex && !pass;
        exp_ok   = ex && known && !exp_fail && !er;
        exp_resp = !exp_fail && er;
        exp_cyc  = exp_fail ? 1 : ws + 1;

        @(negedge clk);
        src_haddr   = a;
        src_hwrite  = wr;
        src_htrans  = 2'b10;
        src_hexcl   = ex;
        src_hmaster = 8'(m);
        src_hsize   = 3'b010;
        src_hburst  = 3'b000;
        src_hprot   = 4'b0011;
        ws_cfg      = ws;
        err_cfg     = er;
        #1;
        check("dst_htrans", 32'(dst_htrans), exp_fail ? 32'd0 : 32'd2);
        check("dst_haddr", dst_haddr, a);
        check("dst_ctrl", 32'({dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwrite}),
              32'({3'b010, 3'b000, 4'b0011, 1'b0, wr}));

        @(posedge clk);
        if (ex && !wr && known) begin
            mv[m] = 1'b1;
            mt[m] = tg;
        end
        if (wr && (!ex || pass)) begin
            for (int i = 0; i < NM; i++) if (mv[i] && mt[i] == tg) mv[i] = 1'b0;
        end
        if (wr && !exp_fail && !er) shadow[idx] = wd;

        #1;
        src_htrans = 2'b00;
        src_hexcl  = 1'b0;
        src_hwdata = wd;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
            rdy = src_hready_resp;
            if (!rdy) check("exokay_in_wait", 32'(src_hexokay), 32'd0);
        end
        check("dp_cycles", 32'(cyc), 32'(exp_cyc));
        check("hexokay", 32'(src_hexokay), 32'(exp_ok));
        check("hresp", 32'(src_hresp), 32'(exp_resp));
        if (!wr && !er && shadow.exists(idx)) check("hrdata", src_hrdata, shadow[idx]);
        @(posedge clk);
    endtask

    logic [31:0] addrs [6];

    initial begin
        addrs = '{32'h1000, 32'h1004, 32'h1008, 32'h2000, 32'h2004, 32'h2010};
        rst_n         = 1'b0;
        src_haddr     = '0;
        src_hwrite    = 1'b0;
        src_htrans    = 2'b00;
        src_hsize     = 3'b010;
        src_hburst    = 3'b000;
        src_hprot     = 4'b0011;
        src_hmastlock = 1'b0;
        src_hwdata    = '0;
        src_hexcl     = 1'b0;
        src_hmaster   = 8'd0;
        repeat (2) @(posedge clk);
        do_reset();

        // M0 reserve then pass; the reservation is consumed by its own write.
        xfer(0, 32'h1000, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        xfer(0, 32'h1000, 1'b1, 1'b1, 32'hA5A5_0001, 0, 1'b0);
        xfer(0, 32'h1000, 1'b1, 1'b1, 32'hDEAD_0001, 0, 1'b0);

        // Plain write by M1 into the same 8-byte granule kills M0's reservation.
        xfer(0, 32'h1000, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        xfer(1, 32'h1004, 1'b1, 1'b0, 32'h0BAD_0004, 1, 1'b0);
        xfer(0, 32'h1000, 1'b1, 1'b1, 32'hDEAD_0002, 2, 1'b0);
        xfer(0, 32'h1000, 1'b0, 1'b0, 32'h0, 0, 1'b0);

        // Both reserve; M1 wins, M0 then fails; memory keeps M1's data.
        xfer(0, 32'h2000, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        xfer(1, 32'h2000, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        xfer(1, 32'h2000, 1'b1, 1'b1, 32'h1111_1111, 0, 1'b0);
        xfer(0, 32'h2000, 1'b1, 1'b1, 32'h2222_2222, 0, 1'b0);
        xfer(0, 32'h2000, 1'b0, 1'b0, 32'h0, 0, 1'b0);

        // No prior reservation, and an out-of-range master ID.
        xfer(0, 32'h1008, 1'b1, 1'b1, 32'h3333_3333, 0, 1'b0);
        xfer(5, 32'h1008, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        xfer(5, 32'h1008, 1'b1, 1'b1, 32'h4444_4444, 0, 1'b0);

        // Passing exclusive pair with 3 slave wait states each.
        xfer(1, 32'h2010, 1'b0, 1'b1, 32'h0, 3, 1'b0);
        xfer(1, 32'h2010, 1'b1, 1'b1, 32'h5555_5555, 3, 1'b0);
        xfer(1, 32'h2010, 1'b0, 1'b0, 32'h0, 1, 1'b0);

        // ERROR on an exclusive read keeps the reservation it made.
        xfer(0, 32'h1000, 1'b0, 1'b1, 32'h0, 0, 1'b1);
        xfer(0, 32'h1000, 1'b1, 1'b1, 32'h6666_6666, 0, 1'b0);

        // Reset discards a live reservation.
        xfer(1, 32'h2004, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        do_reset();
        xfer(1, 32'h2004, 1'b1, 1'b1, 32'h7777_7777, 0, 1'b0);

        // Randomized traffic against the reservation model.
        for (int n = 0; n < 300; n++) begin
            int m;
            m = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2));
            xfer(m, addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_excl_monitor.md
AHBL_EXCL_MONITOR -- requirements
Module: ahbl_excl_monitor

Interface
REQ-001 SHALL have parameter N_MASTERS, 2, number of tracked HMASTER IDs (0..N_MASTERS-1).
REQ-002 SHALL have parameter W_ADDR, 32, address width.
REQ-003 SHALL have parameter W_DATA, 32, data width.
REQ-004 SHALL have parameter GRANULE_LOG2, 3, log2 bytes of reservation granule.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports src_hready in 1, src_haddr in W_ADDR, src_hwrite in 1, src_htrans in 2, src_hsize in 3, src_hburst in 3, src_hprot in 4, src_hmastlock in 1, src_hwdata in W_DATA: the upstream AHBL request, i.e. the arbiter's dst_* outputs.
REQ-008 SHALL have ports src_hexcl in 1 (exclusive request) and src_hmaster in 8 (requesting master ID).
REQ-009 SHALL have ports src_hready_resp out 1, src_hresp out 1, src_hrdata out W_DATA, src_hexokay out 1: the upstream response.
REQ-010 SHALL have ports dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata as outputs, with the same widths as src_*: the downstream slave request.
REQ-011 SHALL have ports dst_hready_resp in 1, dst_hresp in 1, dst_hrdata in W_DATA: the slave response.

Function
REQ-012 SHALL pass all src_* request signals combinationally to dst_*, except that dst_htrans SHALL be forced to 2'b00 for a failing exclusive write.
REQ-013 SHALL treat an address phase as accepted when src_hready && src_htrans[1].
REQ-014 SHALL hold one reservation slot per master: a valid bit plus tag = haddr[W_ADDR-1:GRANULE_LOG2].
REQ-015 On an accepted exclusive read, SHALL set the valid bit and load the tag of slot src_hmaster, replacing any prior reservation from that master.
REQ-016 SHALL pass an accepted exclusive write when slot src_hmaster is valid and its tag matches; otherwise the write fails.
REQ-017 On a passing exclusive write, SHALL clear every slot whose tag matches, including the slot of the writer.
REQ-018 On an accepted non-exclusive write, SHALL clear every slot whose tag matches.
REQ-019 A failing exclusive write SHALL NOT alter any slot.
REQ-020 Reservation updates SHALL be registered at the acceptance edge and be visible to the next address phase; the check SHALL use pre-update state.
REQ-021 When src_hmaster >= N_MASTERS, SHALL not reserve on an exclusive read, and an exclusive write SHALL always fail.
REQ-022 SHALL register the data-phase flags dp_excl and dp_fail at acceptance; both SHALL be cleared when src_hready is high with no accepted transfer.
REQ-023 During a normal data phase, SHALL drive src_hready_resp=dst_hready_resp, src_hresp=dst_hresp and src_hrdata=dst_hrdata.
REQ-024 During a failing data phase, SHALL drive src_hready_resp=1, src_hresp=0 and src_hexokay=0, with zero wait states, independent of dst_*.
REQ-025 SHALL drive src_hexokay = dp_excl && !dp_fail && dst_hready_resp && !dst_hresp, and 0 otherwise.
REQ-026 An exclusive read that is not reservable (REQ-021) SHALL still complete normally with src_hexokay=0.
REQ-027 Latency: 0 added cycles for pass-through transfers; a fail response SHALL complete in exactly 1 data-phase cycle.
REQ-028 An ERROR response on an exclusive transfer SHALL NOT roll back a reservation update already committed at acceptance.

Reset
REQ-029 While rst_n is low at a clk edge, all slot valid bits, dp_excl and dp_fail SHALL clear; tags are don't-care.
REQ-030 Out of reset, outputs SHALL be src_hready_resp=dst_hready_resp, src_hresp=dst_hresp and src_hexokay=0.
REQ-031 Reset asserted mid-transfer SHALL discard all reservations and any pending fail response.

Structure
REQ-032 HTRANS encodings and default GRANULE_LOG2 SHALL live in the shared configuration header included by busfabric blocks.
REQ-033 Tag compare and clear logic SHALL be a generate loop over N_MASTERS; one optional sub-module, excl_resv_slot, SHALL hold a single slot.
REQ-034 The block SHALL instantiate between ahbl_arbiter dst_* and the memory slave; no additional pipeline registers are permitted.

Verification
REQ-035 Master 0 exclusive read 0x1000 then exclusive write 0x1000 -> write reaches dst; src_hexokay=1 in the write's data phase; slot 0 invalid afterwards.
REQ-036 M0 exclusive read 0x1000; M1 plain write 0x1004 (GRANULE_LOG2=3); M0 exclusive write 0x1000 -> dst_htrans=00, src_hexokay=0, src_hready_resp=1 in 1 cycle.
REQ-037 M0 and M1 both exclusive read 0x2000; M1 exclusive write passes -> M0 exclusive write 0x2000 fails, memory holds M1's data.
REQ-038 Exclusive write with no prior read; then src_hmaster=5 exclusive read followed by exclusive write -> both writes fail, and the read returns src_hexokay=0.
REQ-039 Slave inserts 3 wait states on a passing exclusive write -> src_hexokay=1 only in the cycle dst_hready_resp=1.
REQ-040 Reservation set, then rst_n low for 1 cycle, then exclusive write -> write fails.
